sym_cn_lut_pipe: RTL and testbench



---
 rtl/sym_cn_lut_pipe_pkg.sv | 34 +++
 rtl/sym_cn_lut_pipe_if.sv | 59 +++++
 rtl/sym_cn_lut_pipe_bank.sv | 40 ++++
 rtl/sym_cn_lut_pipe.sv | 183 ++++++++++++++++++
 tb/tb_sym_cn_lut_pipe.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sym_cn_lut_pipe_pkg.sv
// ----------------------------------------------------------------------------
// sym_cn_lut_pipe_pkg
// Shared definitions for the symmetric check-node LUT pipeline:
//   - default parameter values for the top and the interface
//   - width-derivation helpers (magnitude, entry address, page address)
//   - load FSM state encoding
// ----------------------------------------------------------------------------
package sym_cn_lut_pipe_pkg;

  localparam int DEF_QUAN_SIZE = 3;
  localparam int DEF_PORT_NUM  = 4;
  localparam int DEF_PAGE_NUM  = 2;

  // Magnitude bits of one message (sign bit stripped).
  function automatic int mag_w(input int quan_size);
    return quan_size - 1;
  endfunction

  // One LUT page is addressed by two magnitudes side by side.
  function automatic int entry_addr_w(input int quan_size);
    return 2 * (quan_size - 1);
  endfunction

  function automatic int page_addr_w(input int page_num);
    return $clog2(page_num);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_t;

endpackage

// File: rtl/sym_cn_lut_pipe_if.sv
// ----------------------------------------------------------------------------
// sym_cn_lut_pipe_if
// Bundles the read stream, the pipeline enable and the LUT load/write stream.
//   master : producer of messages and LUT contents (testbench / upstream)
//   slave  : the sym_cn_lut_pipe block
//
// Handshake semantics:
//   - Read stream has no back-pressure. A beat is taken on a rising clock edge
//     where in_valid=1 and pipe_en=1; pipe_en=0 freezes the pipeline and no
//     beat is taken. out_valid/t_c/out_page/out_err change only on edges with
//     pipe_en=1.
//   - Write stream is strict valid/ready: an entry transfers on a rising edge
//     where wr_valid=1 and wr_ready=1. wr_data must be stable while wr_valid
//     is high; wr_ready does not depend combinationally on wr_valid.
// ----------------------------------------------------------------------------
interface sym_cn_lut_pipe_if #(
  parameter int QUAN_SIZE = sym_cn_lut_pipe_pkg::DEF_QUAN_SIZE,
  parameter int PORT_NUM  = sym_cn_lut_pipe_pkg::DEF_PORT_NUM,
  parameter int PAGE_NUM  = sym_cn_lut_pipe_pkg::DEF_PAGE_NUM
);
  localparam int MAG       = QUAN_SIZE - 1;
  localparam int PAGE_ADDR = $clog2(PAGE_NUM);
  localparam int BUS_W     = PORT_NUM * QUAN_SIZE;

  // read stream
  logic [BUS_W-1:0]     y0_in;
  logic [BUS_W-1:0]     y1_in;
  logic                 in_valid;
  logic [PAGE_ADDR-1:0] rd_page;
  logic                 pipe_en;
  logic [BUS_W-1:0]     t_c;
  logic                 out_valid;
  logic [PAGE_ADDR-1:0] out_page;
  logic                 out_err;

  // load stream
  logic                 load_start;
  logic [PAGE_ADDR-1:0] load_page;
  logic                 wr_valid;
  logic [MAG-1:0]       wr_data;
  logic                 wr_ready;
  logic [PAGE_NUM-1:0]  page_valid;
  logic                 load_done;

  modport master (
    output y0_in, y1_in, in_valid, rd_page, pipe_en,
    output load_start, load_page, wr_valid, wr_data,
    input  t_c, out_valid, out_page, out_err,
    input  wr_ready, page_valid, load_done
  );

  modport slave (
    input  y0_in, y1_in, in_valid, rd_page, pipe_en,
    input  load_start, load_page, wr_valid, wr_data,
    output t_c, out_valid, out_page, out_err,
    output wr_ready, page_valid, load_done
  );

endinterface

// File: rtl/sym_cn_lut_pipe_bank.sv
// ----------------------------------------------------------------------------
// sym_cn_lut_bank
// Paged LUT storage: 2^ADDR_W entries of MAG bits, one synchronous write
// port and PORT_NUM asynchronous read ports. Storage is not reset.
// Because reads are combinational and the write commits at the clock edge,
// a read registered on the same edge as a write to that entry sees old data.
//   clk      : write clock
//   wr_en    : write strobe
//   wr_addr  : {page, entry} write address
//   wr_data  : magnitude to store
//   rd_addr  : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  : packed read data,     port i at [i*MAG +: MAG]
// ----------------------------------------------------------------------------
module sym_cn_lut_bank #(
  parameter int MAG      = 2,
  parameter int ADDR_W   = 5,
  parameter int PORT_NUM = 4
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [MAG-1:0]             wr_data,
  input  logic [PORT_NUM*ADDR_W-1:0] rd_addr,
  output logic [PORT_NUM*MAG-1:0]    rd_data
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [MAG-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_rd
    assign rd_data[g*MAG +: MAG] = mem[rd_addr[g*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/sym_cn_lut_pipe.sv
// ----------------------------------------------------------------------------
// sym_cn_lut_pipe
// Two-stage check-node lookup for PORT_NUM channels sharing one paged LUT,
// plus a load engine that streams one page of LUT entries at a time.
//   read_clk  : system clock
//   rstn      : asynchronous active-low reset
//   bus       : sym_cn_lut_pipe_if.slave (read stream, pipe_en, load stream)
//   dbg_state : current load FSM state
// Stage 0 folds each message pair onto sign + two magnitudes; stage 1 looks
// the magnitudes up in the selected page. Unloaded pages return magnitude 0
// with out_err set.
// ----------------------------------------------------------------------------
module sym_cn_lut_pipe
  import sym_cn_lut_pipe_pkg::*;
#(
  parameter int QUAN_SIZE = DEF_QUAN_SIZE,
  parameter int PORT_NUM  = DEF_PORT_NUM,
  parameter int PAGE_NUM  = DEF_PAGE_NUM
) (
  input  logic             read_clk,
  input  logic             rstn,
  sym_cn_lut_pipe_if.slave bus,
  output load_state_t      dbg_state
);
  localparam int MAG        = mag_w(QUAN_SIZE);
  localparam int ENTRY_ADDR = entry_addr_w(QUAN_SIZE);
  localparam int PAGE_ADDR  = page_addr_w(PAGE_NUM);
  localparam int LUT_ADDR   = PAGE_ADDR + ENTRY_ADDR;
  localparam int BUS_W      = PORT_NUM * QUAN_SIZE;

  // ---------------- stage 0 ----------------
  logic [PORT_NUM-1:0]     sign_c;
  logic [PORT_NUM*MAG-1:0] y0m_c, y1m_c;

  logic                    s0_valid;
  logic [PAGE_ADDR-1:0]    s0_page;
  logic [PORT_NUM-1:0]     s0_sign;
  logic [PORT_NUM*MAG-1:0] s0_y0m, s0_y1m;

  // ---------------- stage 1 ----------------
  logic [PORT_NUM*LUT_ADDR-1:0] rd_addr;
  logic [PORT_NUM*MAG-1:0]      rd_data;
  logic [PORT_NUM*MAG-1:0]      mag_c;
  logic [BUS_W-1:0]             tc_c;
  logic                         page_ok;

  logic                 out_valid_q;
  logic [PAGE_ADDR-1:0] out_page_q;
  logic                 out_err_q;
  logic [BUS_W-1:0]     tc_q;

  // ---------------- load engine ----------------
  load_state_t           state_q, state_d;
  logic [ENTRY_ADDR-1:0] counter_q;
  logic [PAGE_ADDR-1:0]  load_page_q;
  logic [PAGE_NUM-1:0]   page_valid_q;
  logic                  wr_ready;
  logic                  load_done;
  logic                  wr_en;

  assign page_ok = page_valid_q[s0_page];

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_ch
    logic [QUAN_SIZE-1:0] y0, y1;
    assign y0 = bus.y0_in[g*QUAN_SIZE +: QUAN_SIZE];
    assign y1 = bus.y1_in[g*QUAN_SIZE +: QUAN_SIZE];

    // Symmetry folding: y0 magnitude is always inverted, y1 magnitude only
    // when y1 is negative, so one quadrant of the table covers all inputs.
    assign sign_c[g]            = ~(y0[MAG] ^ y1[MAG]);
    assign y0m_c[g*MAG +: MAG]  = ~y0[MAG-1:0];
    assign y1m_c[g*MAG +: MAG]  = y1[MAG] ? ~y1[MAG-1:0] : y1[MAG-1:0];

    assign rd_addr[g*LUT_ADDR +: LUT_ADDR] =
      {s0_page, s0_y0m[g*MAG +: MAG], s0_y1m[g*MAG +: MAG]};
    assign mag_c[g*MAG +: MAG] = page_ok ? rd_data[g*MAG +: MAG] : '0;
    assign tc_c[g*QUAN_SIZE +: QUAN_SIZE] = {s0_sign[g], mag_c[g*MAG +: MAG]};
  end

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      s0_valid <= 1'b0;
      s0_page  <= '0;
      s0_sign  <= '0;
      s0_y0m   <= '0;
      s0_y1m   <= '0;
    end else if (bus.pipe_en) begin
      s0_valid <= bus.in_valid;
      s0_page  <= bus.rd_page;
      s0_sign  <= sign_c;
      s0_y0m   <= y0m_c;
      s0_y1m   <= y1m_c;
    end
  end

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_page_q  <= '0;
      out_err_q   <= 1'b0;
      tc_q        <= '0;
    end else if (bus.pipe_en) begin
      out_valid_q <= s0_valid;
      out_page_q  <= s0_page;
      out_err_q   <= s0_valid & ~page_ok;
      tc_q        <= tc_c;
    end
  end

  sym_cn_lut_bank #(
    .MAG      (MAG),
    .ADDR_W   (LUT_ADDR),
    .PORT_NUM (PORT_NUM)
  ) u_bank (
    .clk     (read_clk),
    .wr_en   (wr_en),
    .wr_addr ({load_page_q, counter_q}),
    .wr_data (bus.wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Load FSM: next state and Moore outputs.
  always_comb begin
    state_d   = state_q;
    wr_ready  = 1'b0;
    load_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        wr_ready = 1'b1;
        // counter all-ones marks the final entry of the page
        if (bus.wr_valid && (&counter_q)) state_d = ST_DONE;
      end
      ST_DONE: begin
        load_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_en = wr_ready & bus.wr_valid;

  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      counter_q    <= '0;
      load_page_q  <= '0;
      page_valid_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (bus.load_start) begin
            load_page_q                  <= bus.load_page;
            counter_q                    <= '0;
            page_valid_q[bus.load_page]  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (bus.wr_valid) counter_q <= counter_q + 1'b1;
        end
        ST_DONE: begin
          page_valid_q[load_page_q] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.t_c        = tc_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_page   = out_page_q;
  assign bus.out_err    = out_err_q;
  assign bus.wr_ready   = wr_ready;
  assign bus.load_done  = load_done;
  assign bus.page_valid = page_valid_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sym_cn_lut_pipe.sv
// ----------------------------------------------------------------------------
// tb_sym_cn_lut_pipe
// Self-checking bench for sym_cn_lut_pipe with the default parameters.
// Expected beats come from a reference model of the folding + LUT contents
// and are queued when a beat is driven; a monitor pops them as they emerge.
// ----------------------------------------------------------------------------
module tb_sym_cn_lut_pipe;
  import sym_cn_lut_pipe_pkg::*;

  localparam int Q          = 3;
  localparam int P          = 4;
  localparam int PG         = 2;
  localparam int MAG        = Q - 1;
  localparam int ENTRY_ADDR = 2 * MAG;
  localparam int ENTRY_NUM  = 1 << ENTRY_ADDR;
  localparam int PAGE_ADDR  = $clog2(PG);
  localparam int BUS_W      = P * Q;
  localparam int W          = 1 + PAGE_ADDR + BUS_W;
  localparam logic [MAG-1:0] MAG_MAX = '1;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rstn;
  load_state_t dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sym_cn_lut_pipe_if #(.QUAN_SIZE(Q), .PORT_NUM(P), .PAGE_NUM(PG)) bus ();

  sym_cn_lut_pipe #(.QUAN_SIZE(Q), .PORT_NUM(P), .PAGE_NUM(PG)) dut (
    .read_clk  (clk),
    .rstn      (rstn),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- model + scoreboard ----------------
  logic [MAG-1:0]  model_mem [PG][ENTRY_NUM];
  logic [PG-1:0]   model_valid;
  logic [W-1:0]    exp_q[$];
  int              stamp_q[$];
  int              total = 0;
  int              bad   = 0;
  int              en_cnt = 0;
  bit              en_seen = 1'b0;

  function automatic logic [MAG-1:0] pat(input int p, input int k);
    int v;
    v = (p == 0) ? k : (3 * k + 1);
    return MAG'(v);
  endfunction

  function automatic logic [W-1:0] expect_beat(input logic [PAGE_ADDR-1:0] page,
                                               input logic [BUS_W-1:0] y0,
                                               input logic [BUS_W-1:0] y1);
    logic [BUS_W-1:0]      tc;
    logic [Q-1:0]          q0, q1;
    logic [MAG-1:0]        a0, a1, m;
    logic [ENTRY_ADDR-1:0] idx;
    logic                  s;
    tc = '0;
    for (int ch = 0; ch < P; ch++) begin
      q0  = y0[ch*Q +: Q];
      q1  = y1[ch*Q +: Q];
      s   = (q0[Q-1] == q1[Q-1]);
      a0  = MAG_MAX - q0[MAG-1:0];
      a1  = q1[Q-1] ? (MAG_MAX - q1[MAG-1:0]) : q1[MAG-1:0];
      idx = {a0, a1};
      m   = model_valid[page] ? model_mem[page][idx] : '0;
      tc[ch*Q +: Q] = {s, m};
    end
    return {~model_valid[page], page, tc};
  endfunction

  always @(posedge clk) begin
    en_seen = bus.pipe_en;
    if (bus.pipe_en) en_cnt++;
  end

  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    int st;
    if (rstn && en_seen && bus.out_valid) begin
      got = {bus.out_err, bus.out_page, bus.t_c};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat: got %h, none expected", got);
      end else begin
        exp = exp_q.pop_front();
        st  = stamp_q.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL beat {err,page,t_c}: got %h exp %h", got, exp);
        end
        total++;
        if (en_cnt - st != 2) begin
          bad++;
          $display("FAIL latency: got %0d exp 2 enabled cycles", en_cnt - st);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit en);
    bus.pipe_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PAGE_ADDR-1:0] page,
                      input logic [BUS_W-1:0] y0, input logic [BUS_W-1:0] y1);
    bus.in_valid = 1'b1;
    bus.rd_page  = page;
    bus.y0_in    = y0;
    bus.y1_in    = y1;
    exp_q.push_back(expect_beat(page, y0, y1));
    stamp_q.push_back(en_cnt);
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    repeat (6) step(1'b1);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d beats outstanding, exp 0", exp_q.size());
      exp_q.delete();
      stamp_q.delete();
    end
  endtask

  task automatic do_load(input int p, input bit gaps, input bit traffic);
    int acc_n, cyc, dones;
    bit acc;
    bus.pipe_en    = 1'b1;
    bus.in_valid   = 1'b0;
    bus.load_page  = PAGE_ADDR'(p);
    bus.load_start = 1'b1;
    @(posedge clk);
    #1;
    bus.load_start = 1'b0;
    model_valid[p] = 1'b0;
    total++;
    if (dbg_state !== ST_LOAD || bus.page_valid[p] !== 1'b0) begin
      bad++;
      $display("FAIL load_enter: state %0d page_valid %b", dbg_state, bus.page_valid);
    end
    acc_n = 0; cyc = 0; dones = 0;
    while (acc_n < ENTRY_NUM && cyc < 2000) begin
      bus.wr_valid   = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.wr_data    = pat(p, acc_n);
      bus.load_start = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.load_page  = PAGE_ADDR'((p + 1) % PG);
      if (traffic)
        send(PAGE_ADDR'((p + 1) % PG), BUS_W'($urandom), BUS_W'($urandom));
      else
        bus.in_valid = 1'b0;
      @(negedge clk);
      acc = bus.wr_valid && bus.wr_ready;
      if (bus.load_done) dones++;
      @(posedge clk);
      #1;
      if (acc) begin
        model_mem[p][acc_n] = pat(p, acc_n);
        acc_n++;
      end
      cyc++;
    end
    bus.wr_valid   = 1'b0;
    bus.load_start = 1'b0;
    bus.in_valid   = 1'b0;
    total++;
    if (acc_n != ENTRY_NUM) begin
      bad++;
      $display("FAIL load_accept: got %0d writes exp %0d", acc_n, ENTRY_NUM);
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL load_done_early: got %0d pulses exp 0", dones);
    end
    @(negedge clk);
    total++;
    if (bus.load_done !== 1'b1 || bus.wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL load_done_pulse: done %b ready %b exp 1 0", bus.load_done, bus.wr_ready);
    end
    @(posedge clk);
    #1;
    model_valid[p] = 1'b1;
    @(negedge clk);
    total++;
    if (bus.load_done !== 1'b0 || bus.page_valid !== model_valid || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL load_finish: done %b page_valid %b exp %b state %0d",
               bus.load_done, bus.page_valid, model_valid, dbg_state);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    bus.y0_in = '0; bus.y1_in = '0; bus.in_valid = 1'b0; bus.rd_page = '0;
    bus.pipe_en = 1'b0; bus.load_start = 1'b0; bus.load_page = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0;
    model_valid = '0;
    #22;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_err !== 1'b0 || bus.out_page !== '0) begin
      bad++;
      $display("FAIL reset_out: valid %b err %b page %b exp 0", bus.out_valid, bus.out_err, bus.out_page);
    end
    total++;
    if (bus.t_c !== '0) begin
      bad++;
      $display("FAIL reset_tc: got %h exp 0", bus.t_c);
    end
    total++;
    if (bus.wr_ready !== 1'b0 || bus.load_done !== 1'b0 || bus.page_valid !== '0) begin
      bad++;
      $display("FAIL reset_load: ready %b done %b page_valid %b exp 0",
               bus.wr_ready, bus.load_done, bus.page_valid);
    end
    total++;
    if (dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unloaded_read();
    send(1'b1, BUS_W'($urandom), BUS_W'($urandom));
    step(1'b1);
    send(1'b0, BUS_W'($urandom), BUS_W'($urandom));
    step(1'b1);
    drain();
  endtask

  task automatic test_directed();
    send(1'b0, '0, '0);
    step(1'b1);
    send(1'b0, {4{3'b100}}, {4{3'b011}});
    step(1'b1);
    bus.in_valid = 1'b0;
    total++;
    if (bus.t_c !== {4{3'b100}} || bus.out_err !== 1'b0 || bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL directed_zero: t_c %h exp %h err %b", bus.t_c, {4{3'b100}}, bus.out_err);
    end
    step(1'b1);
    total++;
    if (bus.t_c !== {4{3'b011}} || bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL directed_mixed: t_c %h exp %h", bus.t_c, {4{3'b011}});
    end
    for (int i = 0; i < 10; i++) begin
      send(1'b0, BUS_W'($urandom), BUS_W'($urandom));
      step(1'b1);
    end
    drain();
  endtask

  task automatic test_after_load();
    for (int i = 0; i < 10; i++) begin
      send(PAGE_ADDR'($urandom_range(0, PG - 1)), BUS_W'($urandom), BUS_W'($urandom));
      step(1'b1);
    end
    drain();
  endtask

  task automatic test_stall();
    logic [W:0] snap;
    send(1'b0, BUS_W'($urandom), BUS_W'($urandom));
    step(1'b1);
    send(1'b1, BUS_W'($urandom), BUS_W'($urandom));
    step(1'b1);
    snap = {bus.out_valid, bus.out_err, bus.out_page, bus.t_c};
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.rd_page  = PAGE_ADDR'($urandom_range(0, PG - 1));
      bus.y0_in    = BUS_W'($urandom);
      bus.y1_in    = BUS_W'($urandom);
      step(1'b0);
      @(negedge clk);
      total++;
      if ({bus.out_valid, bus.out_err, bus.out_page, bus.t_c} !== snap) begin
        bad++;
        $display("FAIL stall_hold: got %h exp %h",
                 {bus.out_valid, bus.out_err, bus.out_page, bus.t_c}, snap);
      end
    end
    send(1'b0, BUS_W'($urandom), BUS_W'($urandom));
    step(1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    bit en;
    for (int i = 0; i < 60; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if (en && $urandom_range(0, 3) != 0) begin
        send(PAGE_ADDR'($urandom_range(0, PG - 1)), BUS_W'($urandom), BUS_W'($urandom));
      end else begin
        bus.in_valid = en ? 1'b0 : 1'b1;
        bus.y0_in    = BUS_W'($urandom);
        bus.y1_in    = BUS_W'($urandom);
      end
      step(en);
    end
    drain();
  endtask

  task automatic test_reset_mid_load();
    bus.pipe_en    = 1'b1;
    bus.load_page  = 1'b0;
    bus.load_start = 1'b1;
    step(1'b1);
    bus.load_start = 1'b0;
    model_valid[0] = 1'b0;
    bus.wr_valid   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.wr_data = pat(0, k);
      step(1'b1);
    end
    bus.wr_valid = 1'b0;
    send(1'b1, BUS_W'($urandom), BUS_W'($urandom));
    step(1'b1);
    bus.in_valid = 1'b0;
    step(1'b1);
    total++;
    if (bus.out_valid !== 1'b1 || dbg_state !== ST_LOAD) begin
      bad++;
      $display("FAIL pre_reset: out_valid %b state %0d exp 1 %0d", bus.out_valid, dbg_state, ST_LOAD);
    end
    #1;
    rstn = 1'b0;
    #1;
    total++;
    if (dbg_state !== ST_IDLE || bus.page_valid !== '0 || bus.out_valid !== 1'b0 ||
        bus.wr_ready !== 1'b0 || bus.t_c !== '0) begin
      bad++;
      $display("FAIL async_reset: state %0d page_valid %b out_valid %b wr_ready %b t_c %h",
               dbg_state, bus.page_valid, bus.out_valid, bus.wr_ready, bus.t_c);
    end
    exp_q.delete();
    stamp_q.delete();
    model_valid = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, BUS_W'($urandom), BUS_W'($urandom));
    step(1'b1);
    drain();
    do_load(0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send(1'b0, BUS_W'($urandom), BUS_W'($urandom));
      step(1'b1);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_unloaded_read();
    do_load(0, 1'b0, 1'b0);
    test_directed();
    do_load(1, 1'b1, 1'b1);
    test_after_load();
    test_stall();
    test_back_to_back();
    test_reset_mid_load();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL final_queue: %0d outstanding exp 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
